// File: rtl/leve_muldiv.sv
// ---------------------------------------------------------------------------
// leve_muldiv -- multi-cycle RV64M/RV32M multiply/divide unit for the EX stage.
//
// Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus the RV64
// W variants. Requests and results use valid/ready handshakes, so EX stalls
// while an operation is in flight.
//
// Multiplies finish MUL_LAT cycles after the accept edge. Divides run a
// radix-2 restoring divider that produces one quotient bit per cycle, then
// spend one sign-fix cycle. Divide-by-zero and signed overflow skip the
// divider and finish in the cycle after the accept edge.
//
// Parameters
//   XLEN     datapath width, 32 or 64
//   MUL_LAT  multiplier latency in cycles, 1..4
//   W_EN     enables the W-variant ops; must be 0 when XLEN=32
//
// Ports
//   CLK      clock
//   RSTn     asynchronous active-low reset
//   IVALID   operation request
//   IREADY   unit can accept a request (high only in IDLE)
//   IFUNCT3  M-extension funct3
//   IWORD    W variant (OP-32); ignored when W_EN=0
//   IRS1     operand A
//   IRS2     operand B
//   IKILL    flush; abandons any in-flight operation or pending result
//   OVALID   result valid
//   OREADY   consumer accepts the result
//   ORESULT  result; changes only on entry to DONE
// ---------------------------------------------------------------------------
module leve_muldiv #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned MUL_LAT = 2,
  parameter bit          W_EN    = 1'b1
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IVALID,
  output logic            IREADY,
  input  logic [2:0]      IFUNCT3,
  input  logic            IWORD,
  input  logic [XLEN-1:0] IRS1,
  input  logic [XLEN-1:0] IRS2,
  input  logic            IKILL,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [XLEN-1:0] ORESULT
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  state_e state_q, state_d;

  // Operation context latched on accept
  logic [2:0]        funct3_q;
  logic              word_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [CNT_W-1:0]  cnt_q;

  // Divider state
  logic [XLEN-1:0]   div_q;      // |divisor|
  logic [XLEN-1:0]   quo_q;      // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0]   rem_q;      // partial remainder
  logic              neg_quo_q;  // negate quotient in FIX
  logic              neg_rem_q;  // negate remainder in FIX

  logic [XLEN-1:0]   result_q;

  logic accept;

  // -------------------------------------------------------------------------
  // Request-side operand preparation (from the unregistered inputs)
  // -------------------------------------------------------------------------
  logic              word_in;
  logic              div_signed_in;
  logic [XLEN-1:0]   op_a, op_b;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN-1:0]   min_v;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   quo_init;
  logic [CNT_W-1:0]  div_cnt_init;
  logic [XLEN-1:0]   special_res;

  assign word_in       = W_EN & IWORD;
  assign div_signed_in = ~IFUNCT3[0];

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    op_a = IRS1;
    op_b = IRS2;
    if (word_in) begin
      op_a = div_signed_in ? sext32(IRS1[31:0]) : zext32(IRS1[31:0]);
      op_b = div_signed_in ? sext32(IRS2[31:0]) : zext32(IRS2[31:0]);
    end

    sign_a = div_signed_in & op_a[XLEN-1];
    sign_b = div_signed_in & op_b[XLEN-1];
    abs_a  = sign_a ? -op_a : op_a;
    abs_b  = sign_b ? -op_b : op_b;

    // Operands are already extended to XLEN, so the most-negative value of
    // the operation width is compared at full width.
    min_v    = word_in ? ~(XLEN'(32'h7FFF_FFFF)) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op_b == '0);
    div_ovf  = div_signed_in & (op_a == min_v) & (&op_b);

    // Word dividends are pre-shifted so their bit 31 is the first bit the
    // divider consumes; after 32 steps the quotient sits in the low 32 bits.
    quo_init     = word_in ? (abs_a << (XLEN - 32)) : abs_a;
    div_cnt_init = word_in ? CNT_W'(31) : CNT_W'(XLEN - 1);

    special_res = '0;
    if (div_zero) begin
      if (IFUNCT3[1]) special_res = word_in ? sext32(IRS1[31:0]) : IRS1;
      else            special_res = '1;
    end else begin
      // Signed overflow: quotient is the dividend itself, remainder is zero.
      special_res = IFUNCT3[1] ? '0 : op_a;
    end
  end

  // -------------------------------------------------------------------------
  // Multiplier
  // Operands are sign- or zero-extended to 2*XLEN; the low 2*XLEN bits of the
  // modular product are then the exact product for every signedness mix.
  // -------------------------------------------------------------------------
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_ext_a, mul_ext_b;
  logic [2*XLEN-1:0] mul_prod;
  logic [2*XLEN-1:0] mul_src;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_signed = (funct3_q[1:0] == 2'b01) | (funct3_q[1:0] == 2'b10);
  assign mul_b_signed = (funct3_q[1:0] == 2'b01);

  always_comb begin
    mul_ext_a = mul_a_signed ? (2*XLEN)'($signed(a_q)) : (2*XLEN)'(a_q);
    mul_ext_b = mul_b_signed ? (2*XLEN)'($signed(b_q)) : (2*XLEN)'(b_q);
    mul_prod  = mul_ext_a * mul_ext_b;
  end

  // With latency above one, the product is registered once; the latched
  // operands stay stable for the whole MUL phase, so the rest of the latency
  // is available for the multiplier to be retimed into.
  if (MUL_LAT > 1) begin : g_prod_reg
    logic [2*XLEN-1:0] prod_q;
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) prod_q <= '0;
      else       prod_q <= mul_prod;
    end
    assign mul_src = prod_q;
  end else begin : g_prod_comb
    assign mul_src = mul_prod;
  end

  always_comb begin
    mul_res = mul_src[XLEN-1:0];
    if (word_q)                      mul_res = sext32(mul_src[31:0]);
    else if (funct3_q[1:0] != 2'b00) mul_res = mul_src[2*XLEN-1:XLEN];
  end

  // -------------------------------------------------------------------------
  // Restoring divider step and sign fix-up
  // -------------------------------------------------------------------------
  logic [XLEN:0]   div_shifted, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] quo_fixed, rem_fixed, fix_sel, fix_res;

  always_comb begin
    div_shifted = {rem_q, quo_q[XLEN-1]};
    div_diff    = div_shifted - {1'b0, div_q};
    div_ge      = ~div_diff[XLEN];
    rem_step    = div_ge ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
    quo_step    = {quo_q[XLEN-2:0], div_ge};

    quo_fixed = neg_quo_q ? -quo_q : quo_q;
    rem_fixed = neg_rem_q ? -rem_q : rem_q;
    fix_sel   = funct3_q[1] ? rem_fixed : quo_fixed;
    fix_res   = word_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (IKILL) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IVALID) begin
            if (!IFUNCT3[2])            state_d = S_MUL;
            else if (div_zero | div_ovf) state_d = S_DONE;
            else                         state_d = S_DIV;
          end
        end
        S_MUL:   if (cnt_q == '0) state_d = S_DONE;
        S_DIV:   if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  if (OREADY) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    IREADY = (state_q == S_IDLE);
    OVALID = (state_q == S_DONE);
  end

  assign accept  = IVALID & IREADY & ~IKILL;
  assign ORESULT = result_q;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic            load_result;
  logic [XLEN-1:0] next_result;

  // The result register loads only on entry to DONE; a kill keeps the FSM
  // out of DONE, so an abandoned operation never disturbs ORESULT.
  assign load_result = (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    case (state_q)
      S_IDLE:  next_result = special_res;
      S_MUL:   next_result = mul_res;
      default: next_result = fix_res;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: datapath registers are reset as well, because ORESULT and the
    // counter must read zero straight out of reset, even mid-operation.
    if (!RSTn) begin
      funct3_q  <= '0;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        funct3_q  <= IFUNCT3;
        word_q    <= word_in;
        a_q       <= IRS1;
        b_q       <= IRS2;
        cnt_q     <= IFUNCT3[2] ? div_cnt_init : CNT_W'(MUL_LAT - 1);
        div_q     <= abs_b;
        quo_q     <= quo_init;
        rem_q     <= '0;
        neg_quo_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
      end else begin
        case (state_q)
          S_MUL: cnt_q <= cnt_q - CNT_W'(1);
          S_DIV: begin
            cnt_q <= cnt_q - CNT_W'(1);
            rem_q <= rem_step;
            quo_q <= quo_step;
          end
          default: ;
        endcase
      end

      if (load_result) result_q <= next_result;
    end
  end

endmodule

// File: tb/tb_leve_muldiv.sv
// ---------------------------------------------------------------------------
// tb_leve_muldiv -- directed self-checking bench for leve_muldiv
// (XLEN=64, MUL_LAT=2, W_EN=1).
//
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point. Latency is counted as rising edges after the accept edge until
// OVALID is seen high: MUL_LAT for multiplies, W+1 for divides, and 0 for
// special-case divides, which reach DONE on the accept edge itself.
// ---------------------------------------------------------------------------
module tb_leve_muldiv;

  localparam int XLEN = 64;

  logic            CLK;
  logic            RSTn;
  logic            IVALID;
  logic            IREADY;
  logic [2:0]      IFUNCT3;
  logic            IWORD;
  logic [XLEN-1:0] IRS1;
  logic [XLEN-1:0] IRS2;
  logic            IKILL;
  logic            OVALID;
  logic            OREADY;
  logic [XLEN-1:0] ORESULT;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  leve_muldiv #(
    .XLEN    (XLEN),
    .MUL_LAT (2),
    .W_EN    (1'b1)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .IVALID  (IVALID),
    .IREADY  (IREADY),
    .IFUNCT3 (IFUNCT3),
    .IWORD   (IWORD),
    .IRS1    (IRS1),
    .IRS2    (IRS2),
    .IKILL   (IKILL),
    .OVALID  (OVALID),
    .OREADY  (OREADY),
    .ORESULT (ORESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it across one rising edge (the accept edge).
  task automatic start_op(input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    IFUNCT3 = f3;
    IWORD   = w;
    IRS1    = a;
    IRS2    = b;
    IVALID  = 1'b1;
    @(posedge CLK);
    #1;
    IVALID  = 1'b0;
  endtask

  // Count edges until OVALID is high; bounded so a dead unit cannot hang.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (OVALID !== 1'b1 && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic take_result();
    OREADY = 1'b1;
    @(posedge CLK);
    #1;
    OREADY = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input int exp_lat, input logic [63:0] exp_res);
    int lat;
    start_op(f3, w, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, ORESULT, exp_res);
    take_result();
    check({tag, "_ready_after"}, {63'b0, IREADY}, 64'd1);
  endtask

  initial begin
    int lat;
    int seen;

    RSTn    = 1'b0;
    IVALID  = 1'b0;
    IFUNCT3 = '0;
    IWORD   = 1'b0;
    IRS1    = '0;
    IRS2    = '0;
    IKILL   = 1'b0;
    OREADY  = 1'b0;

    // Reset state
    #3;
    check("rst_iready",  {63'b0, IREADY}, 64'd1);
    check("rst_ovalid",  {63'b0, OVALID}, 64'd0);
    check("rst_oresult", ORESULT, 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // Multiplies: high halves under each signedness
    do_op("mulh_m1x2",    F_MULH,   1'b0, ONES, 64'd2, 2, ONES);
    do_op("mulhu_m1x2",   F_MULHU,  1'b0, ONES, 64'd2, 2, 64'd1);
    do_op("mulhsu_m1xm1", F_MULHSU, 1'b0, ONES, ONES,  2, ONES);
    do_op("mulh_m1xm1",   F_MULH,   1'b0, ONES, ONES,  2, 64'd0);
    do_op("mulhu_m1xm1",  F_MULHU,  1'b0, ONES, ONES,  2, 64'hFFFF_FFFF_FFFF_FFFE);

    // Full-width signed divide/remainder
    do_op("div_m7_2", F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("rem_m7_2", F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, ONES);

    // Divide by zero
    do_op("divu_5_0", F_DIVU, 1'b0, 64'd5, 64'd0, 0, ONES);
    do_op("remu_5_0", F_REMU, 1'b0, 64'd5, 64'd0, 0, 64'd5);

    // Signed overflow, full width and word
    do_op("div_ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 0, 64'h8000_0000_0000_0000);
    do_op("rem_ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, ONES, 0, 64'd0);
    do_op("divw_ovf", F_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0,
          64'hFFFF_FFFF_8000_0000);

    // Kill mid-divide: no result ever appears, unit is idle right after
    start_op(F_DIVU, 1'b0, 64'd100, 64'd3);
    repeat (9) begin
      @(posedge CLK);
      #1;
    end
    IKILL = 1'b1;
    @(posedge CLK);
    #1;
    IKILL = 1'b0;
    check("kill_div_iready", {63'b0, IREADY}, 64'd1);
    check("kill_div_ovalid", {63'b0, OVALID}, 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge CLK);
      #1;
      if (OVALID === 1'b1) seen++;
    end
    check("kill_div_no_result", 64'(seen), 64'd0);

    // MUL after the kill; then kill the pending result while OREADY is high
    start_op(F_MUL, 1'b0, 64'd6, 64'd7);
    wait_valid(lat);
    check("mul_6x7_lat", 64'(lat), 64'd2);
    check("mul_6x7_res", ORESULT, 64'd42);
    OREADY = 1'b1;
    IKILL  = 1'b1;
    @(posedge CLK);
    #1;
    OREADY = 1'b0;
    IKILL  = 1'b0;
    check("kill_done_ovalid", {63'b0, OVALID}, 64'd0);
    check("kill_done_iready", {63'b0, IREADY}, 64'd1);
    check("kill_done_hold",   ORESULT, 64'd42);

    // IKILL beats IVALID in IDLE: nothing accepted
    IFUNCT3 = F_MUL;
    IWORD   = 1'b0;
    IRS1    = 64'd3;
    IRS2    = 64'd3;
    IVALID  = 1'b1;
    IKILL   = 1'b1;
    @(posedge CLK);
    #1;
    IVALID  = 1'b0;
    IKILL   = 1'b0;
    check("kill_vs_valid_iready", {63'b0, IREADY}, 64'd1);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("kill_vs_valid_ovalid", {63'b0, OVALID}, 64'd0);

    // MULW under backpressure; inputs wander while the result is held
    start_op(F_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2);
    wait_valid(lat);
    check("mulw_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      IRS1 = 64'(i) * 64'h1111_1111_1111_1111;
      check("bp_oresult", ORESULT, 64'hFFFF_FFFF_FFFF_FFFE);
      check("bp_iready",  {63'b0, IREADY}, 64'd0);
      check("bp_ovalid",  {63'b0, OVALID}, 64'd1);
      @(posedge CLK);
      #1;
    end
    take_result();
    check("bp_ready_after", {63'b0, IREADY}, 64'd1);

    // Asynchronous reset in the middle of a divide
    start_op(F_DIV, 1'b0, 64'd1000, 64'd7);
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    #2;
    RSTn = 1'b0;
    #1;
    check("rst_mid_ovalid",  {63'b0, OVALID}, 64'd0);
    check("rst_mid_iready",  {63'b0, IREADY}, 64'd1);
    check("rst_mid_oresult", ORESULT, 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // Word divides: signed remainder and unsigned quotient with upper garbage
    do_op("remw_m7_2", F_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, ONES);
    do_op("divuw_100_7", F_DIVU, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'hABCD_0000_0000_0007, 33,
          64'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
